// File: rtl/alu_op_sequencer_if.sv
// Bundle of the request, ALU-control and response channels around the op sequencer.
// slave is the sequencer's view; master is the decode / ALU / write-back side.
interface alu_op_sequencer_if #(
  parameter int W     = 16,
  parameter int CNT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic             req_cin;
  logic [CNT_W-1:0] req_cnt;

  logic [5:0]       alu_ctrl;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic             alu_cin;
  logic [W-1:0]     alu_y;
  logic             alu_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_y;
  logic             rsp_c;
  logic             rsp_z;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, req_cnt,
    input  alu_y, alu_c, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, alu_cin,
    output rsp_valid, rsp_y, rsp_c, rsp_z, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, req_cnt,
    output alu_y, alu_c, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, alu_cin,
    input  rsp_valid, rsp_y, rsp_c, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences a combinational 16-bit ALU through one requested operation,
// expanding multi-bit shifts/rotates into repeated single-bit passes.
module alu_op_sequencer #(
  parameter int W     = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [3:0]       op_q, op_next;
  logic [W-1:0]     work_q, work_next;
  logic [W-1:0]     breg_q, breg_next;
  logic             carry_q, carry_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             err_q, err_next;
  logic             accept;
  logic             is_shift;

  // Literals are written Ctrl0..Ctrl5 left to right, so bit i of the result is the (5-i)th literal bit.
  function automatic logic [5:0] ctrl_code(input logic [3:0] op);
    logic [5:0] s;
    logic [5:0] r;
    case (op)
      4'd0:    s = 6'b010010;
      4'd1:    s = 6'b010001;
      4'd2:    s = 6'b001010;
      4'd3:    s = 6'b001100;
      4'd4:    s = 6'b001110;
      4'd5:    s = 6'b000110;
      4'd6:    s = 6'b000000;
      4'd7:    s = 6'b011011;
      4'd8:    s = 6'b011000;
      4'd9:    s = 6'b100100;
      4'd10:   s = 6'b100000;
      4'd11:   s = 6'b100010;
      4'd12:   s = 6'b101100;
      4'd13:   s = 6'b101000;
      4'd14:   s = 6'b101010;
      default: s = 6'b000000;
    endcase
    for (int i = 0; i < 6; i++) r[i] = s[5-i];
    return r;
  endfunction

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign is_shift      = (bus.req_op >= 4'd9) && (bus.req_op <= 4'd14);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      breg_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      work_q  <= work_next;
      breg_q  <= breg_next;
      carry_q <= carry_next;
      cnt_q   <= cnt_next;
      err_q   <= err_next;
    end
  end

  // Illegal ops and zero-count shifts bypass EXEC so the ALU is never driven for them.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    work_next  = work_q;
    breg_next  = breg_q;
    carry_next = carry_q;
    cnt_next   = cnt_q;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_next    = bus.req_op;
          work_next  = bus.req_a;
          breg_next  = bus.req_b;
          carry_next = bus.req_cin;
          err_next   = 1'b0;
          if (bus.req_op == 4'd15) begin
            carry_next = 1'b0;
            err_next   = 1'b1;
            cnt_next   = '0;
            state_next = RESP;
          end else if (is_shift) begin
            cnt_next   = bus.req_cnt;
            state_next = (bus.req_cnt == '0) ? RESP : EXEC;
          end else begin
            cnt_next   = CNT_W'(1);
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        work_next  = bus.alu_y;
        carry_next = bus.alu_c;
        cnt_next   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.alu_ctrl  = (state == EXEC) ? ctrl_code(op_q) : 6'b000000;
  assign bus.alu_a     = work_q;
  assign bus.alu_b     = breg_q;
  assign bus.alu_cin   = carry_q;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_y     = (state == RESP) ? work_q : '0;
  assign bus.rsp_c     = (state == RESP) && carry_q;
  assign bus.rsp_z     = (state == RESP) && (work_q == '0);
  assign bus.rsp_err   = (state == RESP) && err_q;

endmodule
